// File: rtl/acc_operand_gen.sv
// acc_operand_gen
//   Streams operand groups from a RAM to an accumulator. An accepted I_start
//   latches the job (base address, operands per group, group count). The block
//   then issues len*grp back-to-back RAM reads and registers the returned data
//   onto O_operand/O_op_rdy, flagging every len-th operand with O_op_last. It
//   finishes by waiting for one I_result_rdy pulse per group and emitting a
//   one-cycle O_done.
//
//   Ports
//     I_clk, I_rst                       clock, async active-low reset
//     I_start, I_base_addr, I_op_len,    job request (sampled only in IDLE)
//     I_grp_num
//     O_ram_rd, O_ram_addr, I_ram_data   RAM read port, read latency L
//     O_operand, O_op_rdy, O_op_last     operand stream to the accumulator
//     I_result_rdy                       one pulse per finished group
//     O_busy, O_done                     job status
//
//   Build option
//     ACC_OPGEN_RDLAT2_EN  defined   : L = 2 (RAM data two cycles after O_ram_rd)
//                          undefined : L = 1
module acc_operand_gen #(
    parameter int C_DATA = 12,
    parameter int C_ADDR = 10,
    parameter int C_LEN  = 8,
    parameter int C_GRP  = 8
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_start,
    input  logic [C_ADDR-1:0] I_base_addr,
    input  logic [C_LEN-1:0]  I_op_len,
    input  logic [C_GRP-1:0]  I_grp_num,
    output logic              O_ram_rd,
    output logic [C_ADDR-1:0] O_ram_addr,
    input  logic [C_DATA-1:0] I_ram_data,
    output logic [C_DATA-1:0] O_operand,
    output logic              O_op_rdy,
    output logic              O_op_last,
    input  logic              I_result_rdy,
    output logic              O_busy,
    output logic              O_done
);

`ifdef ACC_OPGEN_RDLAT2_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif
    // vld_pipe[k] is high k+1 cycles after a read; the last stage lines up
    // with the read data on I_ram_data.
    localparam int STAGES = RD_LAT - 1;

    localparam logic [C_LEN-1:0]  LEN_ONE  = 1;
    localparam logic [C_GRP-1:0]  GRP_ONE  = 1;
    localparam logic [C_ADDR-1:0] ADDR_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT_RES, S_DONE} state_t;

    state_t           state;
    logic [C_LEN-1:0] len_q, rd_elem;
    logic [C_GRP-1:0] grp_q, rd_grp, res_cnt, res_cnt_nxt;
    logic             rd_last_elem, rd_final, res_inc, pipe_empty;
    logic [STAGES:0]  vld_pipe, last_pipe;

    assign rd_last_elem = (rd_elem == len_q - LEN_ONE);
    assign rd_final     = rd_last_elem && (rd_grp == grp_q - GRP_ONE);
    // Result pulses only count while a job is active and saturate at the
    // group count, so stray extra pulses cannot overshoot the target.
    assign res_inc      = I_result_rdy && (state == S_READ || state == S_WAIT_RES)
                          && (res_cnt != grp_q);
    assign res_cnt_nxt  = res_cnt + {{(C_GRP-1){1'b0}}, res_inc};
    assign pipe_empty   = ~|vld_pipe;

    // Control: job latch, read sequencing, result counting.
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            state      <= S_IDLE;
            len_q      <= '0;
            grp_q      <= '0;
            rd_elem    <= '0;
            rd_grp     <= '0;
            res_cnt    <= '0;
            O_ram_rd   <= 1'b0;
            O_ram_addr <= '0;
            O_busy     <= 1'b0;
            O_done     <= 1'b0;
        end else begin
            O_done  <= 1'b0;
            res_cnt <= res_cnt_nxt;
            case (state)
                S_IDLE: begin
                    if (I_start) begin
                        len_q      <= I_op_len;
                        grp_q      <= I_grp_num;
                        rd_elem    <= '0;
                        rd_grp     <= '0;
                        res_cnt    <= '0;
                        O_ram_addr <= I_base_addr;
                        if (I_op_len == '0 || I_grp_num == '0) begin
                            state  <= S_DONE;
                            O_done <= 1'b1;
                        end else begin
                            state    <= S_READ;
                            O_ram_rd <= 1'b1;
                            O_busy   <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    // O_ram_rd is high for every cycle spent here.
                    O_ram_addr <= O_ram_addr + ADDR_ONE;
                    if (rd_last_elem) begin
                        rd_elem <= '0;
                        rd_grp  <= rd_grp + GRP_ONE;
                    end else begin
                        rd_elem <= rd_elem + LEN_ONE;
                    end
                    if (rd_final) begin
                        O_ram_rd <= 1'b0;
                        state    <= S_WAIT_RES;
                    end
                end
                S_WAIT_RES: begin
                    // Empty pipe means the final operand is on O_operand now
                    // or has already gone out.
                    if (pipe_empty && res_cnt_nxt == grp_q) begin
                        state  <= S_DONE;
                        O_done <= 1'b1;
                        O_busy <= 1'b0;
                    end
                end
                default: state <= S_IDLE;  // S_DONE lasts exactly one cycle
            endcase
        end
    end

    // Data path: delay the read strobe and group-end flag to the cycle the
    // RAM data arrives, then register data and flags onto the outputs.
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            O_op_rdy  <= 1'b0;
            O_op_last <= 1'b0;
            O_operand <= '0;
        end else begin
            vld_pipe[0]  <= O_ram_rd;
            last_pipe[0] <= O_ram_rd & rd_last_elem;
            for (int i = 1; i <= STAGES; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
            O_op_rdy  <= vld_pipe[STAGES];
            O_op_last <= vld_pipe[STAGES] & last_pipe[STAGES];
            if (vld_pipe[STAGES])
                O_operand <= I_ram_data;
        end
    end

endmodule

// File: doc/acc_operand_gen.md
ACC_OPERAND_GEN -- requirements
Module: acc_operand_gen

Interface
REQ-001 SHALL have parameter C_DATA, default 12, operand/RAM data width.
REQ-002 SHALL have parameter C_ADDR, default 10, RAM address width.
REQ-003 SHALL have parameter C_LEN, default 8, width of the group-length field.
REQ-004 SHALL have parameter C_GRP, default 8, width of the group-count field.
REQ-005 SHALL have port I_clk  input  1  sole clock, all logic on its rising edge.
REQ-006 SHALL have port I_rst  input  1  asynchronous active-low reset.
REQ-007 SHALL have port I_start  input  1  one-cycle job-start pulse.
REQ-008 SHALL have port I_base_addr  input  C_ADDR  first RAM address of the job.
REQ-009 SHALL have port I_op_len  input  C_LEN  operands per group.
REQ-010 SHALL have port I_grp_num  input  C_GRP  groups per job.
REQ-011 SHALL have port O_ram_rd  output  1  RAM read enable.
REQ-012 SHALL have port O_ram_addr  output  C_ADDR  RAM read address.
REQ-013 SHALL have port I_ram_data  input  C_DATA  RAM read data, valid L cycles after O_ram_rd.
REQ-014 SHALL have port O_operand  output  C_DATA  operand to accumulator.
REQ-015 SHALL have port O_op_rdy  output  1  operand valid.
REQ-016 SHALL have port O_op_last  output  1  marks the last operand of a group; only when O_op_rdy=1.
REQ-017 SHALL have port I_result_rdy  input  1  one pulse per completed accumulator group.
REQ-018 SHALL have port O_busy  output  1  high from start acceptance until O_done.
REQ-019 SHALL have port O_done  output  1  one-cycle job-complete pulse.

Function
REQ-020 SHALL implement FSM IDLE, READ, WAIT_RES, DONE; IDLE->READ on I_start with I_op_len!=0 and I_grp_num!=0.
REQ-021 SHALL latch I_base_addr, I_op_len, I_grp_num on the accepted I_start cycle; later input changes have no effect on the job.
REQ-022 SHALL ignore I_start when not in IDLE.
REQ-023 SHALL, on I_start with I_op_len=0 or I_grp_num=0, go IDLE->DONE with no RAM reads and no operands.
REQ-024 SHALL assert O_ram_rd one cycle after the accepted I_start, for exactly I_op_len*I_grp_num consecutive cycles, no bubbles between groups.
REQ-025 SHALL increment O_ram_addr by 1 per read starting at I_base_addr, wrapping modulo 2^C_ADDR.
REQ-026 SHALL register I_ram_data to O_operand, so O_op_rdy rises L+1 cycles after the matching O_ram_rd.
REQ-027 SHALL assert O_op_last with every I_op_len-th operand, via element and group counters.
REQ-028 SHALL go READ->WAIT_RES after the final read is issued.
REQ-029 SHALL count I_result_rdy pulses in READ and WAIT_RES, ignore them in IDLE/DONE, and ignore pulses beyond I_grp_num.
REQ-030 SHALL go WAIT_RES->DONE once all operands are emitted and the count equals I_grp_num; including a pulse coinciding with the transition.
REQ-031 SHALL hold DONE one cycle (O_done=1), then return to IDLE; an I_start in the DONE cycle is ignored.
REQ-032 SHALL keep O_busy high in READ and WAIT_RES, and low in IDLE and DONE.

Reset
REQ-033 SHALL on I_rst=0, immediately force IDLE and drive O_ram_rd, O_op_rdy, O_op_last, O_busy, O_done low, O_ram_addr and O_operand zero, and clear all counters.
REQ-034 SHALL, when reset is asserted mid-job, discard all in-flight reads and emit no further operands after release.

Configuration
REQ-035 SHALL support macro ACC_OPGEN_RDLAT2_EN: when defined, L=2 (extra capture stage, O_op_rdy 3 cycles after O_ram_rd); when undefined, L=1 (O_op_rdy 2 cycles after O_ram_rd).

Verification
REQ-036 SHALL cover: base=0x010, len=4, grp=2, L=1 -> reads 0x010..0x017 in cycles 1..8, O_op_rdy cycles 3..10, O_op_last at cycles 6 and 10.
REQ-037 SHALL cover: base=0x3FE, len=3, grp=1 -> addresses 0x3FE, 0x3FF, 0x000; one O_op_last; O_done 1 cycle after the I_result_rdy pulse.
REQ-038 SHALL cover: len=0, grp=5 -> no O_ram_rd, no O_op_rdy, O_done the cycle after start, O_busy never high.
REQ-039 SHALL cover: second I_start mid-READ plus extra I_result_rdy pulses -> job unchanged; O_done after exactly grp pulses.
REQ-040 SHALL cover: I_rst low during READ of len=8, grp=4 -> all outputs zero immediately; after release, no operands until a new I_start.
REQ-041 SHALL cover: ACC_OPGEN_RDLAT2_EN defined, len=2, grp=1 -> O_op_rdy cycles 4..5 for reads in cycles 1..2; data matches RAM contents.
